// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl
//   Whack-a-mole game sequencer. A game is ROUNDS rounds. Each round lights one
//   mole (SHOW) until it is hit, missed, or times out, then keeps all moles dark
//   (GAP). After the last round the controller parks in RESULT, pulses done and
//   updates the best score seen since reset.
//
// Ports
//   clk        : system clock, all state on posedge
//   reset      : asynchronous, active-high; clears everything including hiscore
//   start      : level; starts a game when sampled high in IDLE or RESULT
//   btn[3:0]   : debounced, synchronized, active-high mole buttons
//   mole[3:0]  : one-hot lit mole, 0 when none
//   score      : current game score (saturating)
//   hiscore    : best final score since reset
//   busy       : high while in SHOW or GAP
//   done       : one-cycle pulse on entry to RESULT
//   new_record : set in RESULT if this game raised hiscore; cleared on next start
module mole_game_ctrl #(
  parameter int MOLE_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 12_500_000,
  parameter int ROUNDS     = 16,
  parameter int SCORE_W    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         btn,
  output logic [3:0]         mole,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore,
  output logic               busy,
  output logic               done,
  output logic               new_record
);

  localparam int TMAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(TMAX);

  localparam logic [TW-1:0]      MOLE_LAST = TW'(MOLE_TICKS - 1);
  localparam logic [TW-1:0]      GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0]      TIMER_ONE = TW'(1);
  localparam logic [7:0]         ROUND_END = 8'(ROUNDS - 1);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    GAP    = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    round;
  logic [3:0]    btn_q;
  logic [7:0]    lfsr;

  logic [3:0] rise;
  logic       lfsr_fb;
  logic [3:0] next_mole;

  // Only fresh presses count; a button held across cycles produces one rise.
  assign rise = btn & ~btn_q;

  // Fibonacci feedback for x^8+x^6+x^5+x^4+1.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Mole chosen from the LFSR value present on the edge that enters SHOW.
  assign next_mole = 4'b0001 << lfsr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      round      <= '0;
      btn_q      <= '0;
      lfsr       <= 8'hA5;
      mole       <= '0;
      score      <= '0;
      hiscore    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      new_record <= 1'b0;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr_fb};
      btn_q <= btn;
      done  <= 1'b0;

      unique case (state)
        IDLE, RESULT: begin
          if (start) begin
            state      <= SHOW;
            score      <= '0;
            round      <= '0;
            timer      <= '0;
            new_record <= 1'b0;
            mole       <= next_mole;
            busy       <= 1'b1;
          end
        end

        SHOW: begin
          // Any rise ends the round; it scores only if it is exactly the lit mole.
          // This also covers a correct hit landing on the timeout cycle.
          if (rise != 4'b0000) begin
            if (rise == mole && score != SCORE_MAX) score <= score + SCORE_ONE;
            state <= GAP;
            mole  <= '0;
            timer <= '0;
          end else if (timer == MOLE_LAST) begin
            state <= GAP;
            mole  <= '0;
            timer <= '0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (round == ROUND_END) begin
              state <= RESULT;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Strictly greater: a tie keeps the old record and no flag.
              if (score > hiscore) begin
                hiscore    <= score;
                new_record <= 1'b1;
              end
            end else begin
              round <= round + 8'd1;
              state <= SHOW;
              mole  <= next_mole;
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl
//   Directed and randomized game-level stimulus for mole_game_ctrl with
//   MOLE_TICKS=4, GAP_TICKS=2, ROUNDS=3. A second instance with SCORE_W=1 runs
//   on the same stimulus to exercise score saturation and ties at the top value.
//   Expected moles come from an LFSR sequence model indexed by cycles since
//   reset; expected scores come from the bench's own per-round decisions.
module tb_mole_game_ctrl;

  localparam int A_NONE  = 0;
  localparam int A_HIT   = 1;
  localparam int A_WRONG = 2;
  localparam int A_BOTH  = 3;
  localparam int A_HOLD  = 4;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] btn = 4'b0000;
  always #5 clk = ~clk;

  logic [3:0] mole;
  logic [6:0] score, hiscore;
  logic       busy, done, new_record;

  logic [3:0] s_mole;
  logic [0:0] s_score, s_hiscore;
  logic       s_busy, s_done, s_new_record;

  mole_game_ctrl #(.MOLE_TICKS(4), .GAP_TICKS(2), .ROUNDS(3), .SCORE_W(7)) dut (
    .clk(clk), .reset(rst), .start(start), .btn(btn),
    .mole(mole), .score(score), .hiscore(hiscore),
    .busy(busy), .done(done), .new_record(new_record)
  );

  mole_game_ctrl #(.MOLE_TICKS(4), .GAP_TICKS(2), .ROUNDS(3), .SCORE_W(1)) sat_dut (
    .clk(clk), .reset(rst), .start(start), .btn(btn),
    .mole(s_mole), .score(s_score), .hiscore(s_hiscore),
    .busy(s_busy), .done(s_done), .new_record(s_new_record)
  );

  // scoreboard state
  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int m_score = 0, m_hi = 0, m_nr = 0;
  int s_score_m = 0, s_hi = 0, s_nr = 0;
  int act_a[3];
  int dly_a[3];

  // LFSR value n clock edges after reset release: shift left, feedback is
  // the parity of the tapped bits (x^8, x^6, x^5, x^4).
  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], ^(v & 8'hB8)};
    return v;
  endfunction

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Plays one full game using act_a/dly_a. With chain set, start is raised
  // before the final edge and left high so the next game starts from RESULT
  // on the cycle right after done.
  task automatic play_game(input bit chain);
    logic [7:0] lv;
    logic [3:0] lit, wrong;
    int idx;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_score = 0; s_score_m = 0; m_nr = 0; s_nr = 0;
    check("nr_clear", new_record, 0);
    check("s_nr_clear", s_new_record, 0);
    for (int r = 0; r < 3; r++) begin
      lv  = lfsr_at(cyc - 1);
      idx = int'(lv[1:0]);
      lit = 4'b0001 << idx;
      check("mole_show", mole, lit);
      check("s_mole_show", s_mole, lit);
      check("busy_show", busy, 1);
      check("score_show", score, m_score);
      case (act_a[r])
        A_NONE: begin
          repeat (3) begin
            tick();
            check("mole_lit", mole, lit);
          end
          tick();
          check("mole_timeout", mole, 0);
          check("score_timeout", score, m_score);
          btn = 4'b0000;
        end
        A_HIT, A_HOLD: begin
          repeat (dly_a[r]) tick();
          btn = lit;
          tick();
          m_score   = sat_inc(m_score, 127);
          s_score_m = sat_inc(s_score_m, 1);
          check("mole_hit", mole, 0);
          check("score_hit", score, m_score);
          check("s_score_hit", s_score, s_score_m);
          if (act_a[r] == A_HIT) btn = 4'b0000;
        end
        default: begin
          wrong = 4'b0001 << ((idx + 1 + int'($urandom_range(0, 2))) % 4);
          repeat (dly_a[r]) tick();
          btn = (act_a[r] == A_BOTH) ? (lit | wrong) : wrong;
          tick();
          check("mole_miss", mole, 0);
          check("score_miss", score, m_score);
          check("s_score_miss", s_score, s_score_m);
          btn = 4'b0000;
        end
      endcase
      tick();
      check("mole_gap", mole, 0);
      check("busy_gap", busy, 1);
      if (r == 2) begin
        if (chain) start = 1'b1;
        if (m_score > m_hi) begin m_hi = m_score; m_nr = 1; end
        if (s_score_m > s_hi) begin s_hi = s_score_m; s_nr = 1; end
      end
      tick();
    end
    check("done_pulse", done, 1);
    check("busy_result", busy, 0);
    check("score_final", score, m_score);
    check("hiscore", hiscore, m_hi);
    check("new_record", new_record, m_nr);
    check("s_done_pulse", s_done, 1);
    check("s_score_final", s_score, s_score_m);
    check("s_hiscore", s_hiscore, s_hi);
    check("s_new_record", s_new_record, s_nr);
    if (!chain) begin
      tick();
      check("done_drop", done, 0);
      check("score_hold", score, m_score);
      check("nr_hold", new_record, m_nr);
    end
  endtask

  task automatic set_game(input int a0, input int d0, input int a1, input int d1,
                          input int a2, input int d2);
    act_a[0] = a0; dly_a[0] = d0;
    act_a[1] = a1; dly_a[1] = d1;
    act_a[2] = a2; dly_a[2] = d2;
  endtask

  initial begin
    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    repeat (10) tick();
    check("rst_mole", mole, 0);
    check("rst_score", score, 0);
    check("rst_hiscore", hiscore, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nr", new_record, 0);
    check("lfsr_idle", dut.lfsr, lfsr_at(cyc));

    // game 1: every mole hit one cycle after it lights
    set_game(A_HIT, 1, A_HIT, 1, A_HIT, 1);
    play_game(1'b0);

    // game 2: no presses, start held through RESULT into game 3
    set_game(A_NONE, 0, A_NONE, 0, A_NONE, 0);
    play_game(1'b1);

    // game 3: lit+unlit together misses; held button scores once only
    set_game(A_BOTH, 2, A_HOLD, 0, A_NONE, 0);
    play_game(1'b0);

    // game 4: hits at first and timeout cycles; ties hiscore 3 (and 1 on sat_dut)
    set_game(A_HIT, 0, A_HIT, 3, A_HIT, 2);
    play_game(1'b0);

    // randomized games
    for (int g = 0; g < 6; g++) begin
      for (int r = 0; r < 3; r++) begin
        act_a[r] = int'($urandom_range(0, 3));
        dly_a[r] = int'($urandom_range(0, 3));
      end
      play_game(g == 2);
    end
    check("lfsr_run", dut.lfsr, lfsr_at(cyc));

    // reset in the middle of SHOW
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_mole", mole, 0);
    check("arst_score", score, 0);
    check("arst_hiscore", hiscore, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_nr", new_record, 0);
    check("arst_s_hiscore", s_hiscore, 0);
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    m_hi = 0; s_hi = 0;
    repeat (3) tick();
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_mole", mole, 0);
    check("post_rst_lfsr", dut.lfsr, lfsr_at(cyc));

    // a fresh game after reset sets a new record from zero
    set_game(A_HIT, 1, A_HIT, 0, A_HIT, 1);
    play_game(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
